// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing defaults and coordinate width for the sync generator.
package vga_pkg;
   localparam int   VGA_H_ACTIVE = 640;
   localparam int   VGA_H_FP     = 16;
   localparam int   VGA_H_SYNC   = 96;
   localparam int   VGA_H_BP     = 48;
   localparam int   VGA_V_ACTIVE = 480;
   localparam int   VGA_V_FP     = 10;
   localparam int   VGA_V_SYNC   = 2;
   localparam int   VGA_V_BP     = 33;
   localparam int   VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int   VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
   localparam int   COORD_W      = 10;
   localparam logic VGA_SYNC_POL = 1'b0;
endpackage

// File: rtl/vga_sync_gen_pix_tick_gen.sv
// Turns the divided 25 MHz clock, sampled as data on clk, into a one-clk pixel tick.
module pix_tick_gen (
   input  logic clk,
   input  logic rst,
   input  logic clk_25M,
   output logic pix_tick
);
   logic clk_25M_d, clk_25M_q;

   always_comb clk_25M_d = clk_25M;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) clk_25M_q <= 1'b0;
      else      clk_25M_q <= clk_25M_d;
   end

   // gated by rst so no tick escapes while the block is held in reset
   assign pix_tick = rst & clk_25M & ~clk_25M_q;
endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: h/v counters advanced on pix_tick, decode registered one pixel late.
import vga_pkg::*;

module vga_sync_gen #(
   parameter int   H_ACTIVE = VGA_H_ACTIVE,
   parameter int   H_FP     = VGA_H_FP,
   parameter int   H_SYNC   = VGA_H_SYNC,
   parameter int   H_BP     = VGA_H_BP,
   parameter int   V_ACTIVE = VGA_V_ACTIVE,
   parameter int   V_FP     = VGA_V_FP,
   parameter int   V_SYNC   = VGA_V_SYNC,
   parameter int   V_BP     = VGA_V_BP,
   parameter logic SYNC_POL = VGA_SYNC_POL
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clk_25M,
   output logic               pix_tick,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [COORD_W-1:0] h_cnt_d, h_cnt_q, v_cnt_d, v_cnt_q;
   logic [COORD_W-1:0] x_d, x_q, y_d, y_q;
   logic hsync_d, hsync_q, vsync_d, vsync_q;
   logic video_on_d, video_on_q, frame_start_d, frame_start_q;
   logic vis;

   pix_tick_gen u_pix_tick_gen (
      .clk      (clk),
      .rst      (rst),
      .clk_25M  (clk_25M),
      .pix_tick (pix_tick)
   );

   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      video_on_d    = video_on_q;
      frame_start_d = frame_start_q;
      x_d           = x_q;
      y_d           = y_q;
      vis           = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      if (pix_tick) begin
         h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
         if (h_cnt_q == H_LAST)
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
         // decode the pre-tick position so every output lags the counters by one pixel
         hsync_d       = (h_cnt_q >= HS_START && h_cnt_q < HS_END) ? SYNC_POL : ~SYNC_POL;
         vsync_d       = (v_cnt_q >= VS_START && v_cnt_q < VS_END) ? SYNC_POL : ~SYNC_POL;
         video_on_d    = vis;
         frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
         x_d           = vis ? h_cnt_q : '0;
         y_d           = vis ? v_cnt_q : '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         frame_start_q <= frame_start_d;
         x_q           <= x_d;
         y_q           <= y_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign frame_start = frame_start_q;
   assign x           = x_q;
   assign y           = y_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance plus a shrunken-timing one for frame-level behaviour.
module tb_vga_sync_gen;
   logic clk = 1'b0, rst = 1'b0, clk_25M = 1'b0;
   logic div_en = 1'b0;
   int   phase = 3;
   int   n = 0;          // pixel ticks seen since reset release
   logic prev25 = 1'b0;  // clk_25M as last sampled by a clk edge
   int   checks = 0, errors = 0;

   logic d_tick, d_hs, d_vs, d_vid, d_fs;
   logic [9:0] d_x, d_y;
   logic s_tick, s_hs, s_vs, s_vid, s_fs;
   logic [9:0] s_x, s_y;

   always #5 clk = ~clk;

   vga_sync_gen dut (
      .clk(clk), .rst(rst), .clk_25M(clk_25M), .pix_tick(d_tick), .hsync(d_hs),
      .vsync(d_vs), .video_on(d_vid), .x(d_x), .y(d_y), .frame_start(d_fs)
   );

   vga_sync_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
   ) dut_s (
      .clk(clk), .rst(rst), .clk_25M(clk_25M), .pix_tick(s_tick), .hsync(s_hs),
      .vsync(s_vs), .video_on(s_vid), .x(s_x), .y(s_y), .frame_start(s_fs)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   // Outputs after n ticks: reset pattern for n==0, else the decode of pixel (n-1) of the frame.
   // Packing {hsync, vsync, video_on, frame_start, x, y}; sync polarity is active-low.
   function automatic logic [23:0] model(input int cnt, input int ha, input int hf, input int hs,
                                         input int hb, input int va, input int vf, input int vs,
                                         input int vb);
      int ht, vt, p, h, v;
      logic vis;
      if (cnt == 0) return 24'hC00000;
      ht  = ha + hf + hs + hb;
      vt  = va + vf + vs + vb;
      p   = (cnt - 1) % (ht * vt);
      h   = p % ht;
      v   = p / ht;
      vis = (h < ha) && (v < va);
      return {!(h >= ha + hf && h < ha + hf + hs), !(v >= va + vf && v < va + vf + vs), vis,
              (h == 0 && v == 0), vis ? 10'(h) : 10'd0, vis ? 10'(v) : 10'd0};
   endfunction

   // divider model: 2 clk high, 2 clk low, moved just after each clk edge
   always @(posedge clk) begin
      #1;
      if (div_en) begin
         phase   = (phase + 1) % 4;
         clk_25M = (phase < 2);
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      logic exp_tick;
      if (!rst) begin
         chk("rst_dflt", {d_tick, d_hs, d_vs, d_vid, d_fs, d_x, d_y}, {1'b0, 24'hC00000});
         chk("rst_small", {s_tick, s_hs, s_vs, s_vid, s_fs, s_x, s_y}, {1'b0, 24'hC00000});
         n      = 0;
         prev25 = 1'b0;
      end else begin
         exp_tick = clk_25M && !prev25;
         chk("cyc_dflt", {d_tick, d_hs, d_vs, d_vid, d_fs, d_x, d_y},
             {exp_tick, model(n, 640, 16, 96, 48, 480, 10, 2, 33)});
         chk("cyc_small", {s_tick, s_hs, s_vs, s_vid, s_fs, s_x, s_y},
             {exp_tick, model(n, 8, 2, 3, 3, 6, 1, 2, 2)});
         if (exp_tick) n++;
         prev25 = clk_25M;
      end
   end

   task automatic wait_n(input int target);
      int k;
      for (k = 0; k < 20000; k++) begin
         @(posedge clk);
         #2;
         if (n >= target) break;
      end
      if (n < target) begin
         errors++;
         $display("FAIL wait_n got %0d want %0d", n, target);
      end
   endtask

   initial begin
      repeat (5) @(posedge clk);
      #2;
      chk("lit_rst_hsync", 32'(d_hs), 32'd1);
      chk("lit_rst_x", 32'(d_x), 32'd0);
      rst    = 1'b1;
      div_en = 1'b1;

      wait_n(1);
      chk("lit_first_fs", {d_fs, d_vid, d_x, d_y}, {1'b1, 1'b1, 20'd0});
      wait_n(113);   // small: pixel 112 = (0,7), first vsync line
      chk("lit_small_vsync", 32'(s_vs), 32'd0);
      wait_n(177);   // small: pixel 176 wraps (15,10)->(0,0)
      chk("lit_small_wrap_fs", 32'(s_fs), 32'd1);
      wait_n(657);   // pixel 656: hsync asserts
      chk("lit_hsync_on", {d_hs, d_vid, d_x}, {1'b0, 1'b0, 10'd0});
      wait_n(752);   // pixel 751: last hsync pixel
      chk("lit_hsync_last", 32'(d_hs), 32'd0);
      wait_n(753);
      chk("lit_hsync_off", 32'(d_hs), 32'd1);
      wait_n(801);   // pixel 800 = (0,1)
      chk("lit_line1", {d_vid, d_fs, d_x, d_y}, {1'b1, 1'b0, 10'd0, 10'd1});

      wait_n(900);   // hold clk_25M low mid-line at x=99
      div_en  = 1'b0;
      clk_25M = 1'b0;
      repeat (100) @(posedge clk);
      #2;
      chk("lit_hold_x", 32'(d_x), 32'd99);
      phase  = 3;
      div_en = 1'b1;
      wait_n(901);
      chk("lit_resume_x", 32'(d_x), 32'd100);

      wait_n(1101);  // pixel 1100 = (300,1)
      chk("lit_pre_rst_x", {d_x, d_y}, {10'd300, 10'd1});
      rst = 1'b0;
      #1;
      chk("lit_midrst", {d_hs, d_vs, d_vid, d_x, d_y}, {1'b1, 1'b1, 1'b0, 20'd0});
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      wait_n(1);
      chk("lit_restart_fs", {d_fs, d_x, d_y}, {1'b1, 20'd0});
      wait_n(600);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA 640x480@60 timing generator; sits directly downstream of the 4:1 pixel-clock divider and consumes its 25 MHz output as a data signal. Runs on the 100 MHz system clock and advances on a one-cycle pixel tick derived internally from the divided clock. Produces registered hsync/vsync, the active-video flag and pixel coordinates for the snake renderer.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 1'b0, asserted level of hsync/vsync (0 = active-low)

- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- clk_25M  in  1  divided pixel clock from the divider, sampled as data (2 clk high, 2 clk low)
- pix_tick  out  1  one-clk pulse per pixel period
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high while (x,y) is inside the visible area
- x  out  10  pixel column, 0..H_ACTIVE-1 when video_on, else 0
- y  out  10  pixel row, 0..V_ACTIVE-1 when video_on, else 0
- frame_start  out  1  one-pix_tick-period pulse marking pixel (0,0)

## Operation
- Clock decision: everything is clocked on clk; no logic is clocked by clk_25M.
- Tick: clk_25M_q registered each clk; pix_tick = clk_25M & ~clk_25M_q (rising edge detect), combinational from the register, exported.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024; counters 10 bits.
- h_cnt: on pix_tick, h_cnt == H_TOTAL-1 → 0, else +1. v_cnt: on pix_tick with h_cnt == H_TOTAL-1, v_cnt == V_TOTAL-1 → 0, else +1. No tick → both hold.
- Decode (from current h_cnt/v_cnt, registered on pix_tick):
  - hsync = SYNC_POL when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), else ~SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), else ~SYNC_POL.
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - x = video_on ? h_cnt : 0; y = video_on ? v_cnt : 0.
  - frame_start = (h_cnt == 0) && (v_cnt == 0); held for the pixel period.
- Reset values (async, immediate): h_cnt=0, v_cnt=0, clk_25M_q=0, hsync=~SYNC_POL, vsync=~SYNC_POL, video_on=0, x=0, y=0, frame_start=0. pix_tick=0 while rst low.
- Reset mid-frame: all state returns to reset values; after release, first tick decodes pixel (0,0).
- clk_25M stuck (high or low): no ticks; counters and outputs hold indefinitely.

## Timing
- pix_tick asserts in the clk cycle where clk_25M is first sampled high; period 4 clk with the divider running.
- Output latency: hsync/vsync/video_on/x/y/frame_start reflect the counter values present before a tick, updated on that tick's clk edge; uniform one-pixel latency, all outputs mutually aligned.
- Outputs change only on clk edges where pix_tick = 1.
- Line: 800 ticks; hsync asserted 96 ticks. Frame: 525 lines = 420000 ticks; vsync asserted 2 lines (1600 ticks).
- Simultaneous h and v wrap (799,524) → both to 0 on the same tick; next tick decodes frame_start.

## Structure
- Shared package vga_pkg: default timing constants (H_*/V_*), derived H_TOTAL/V_TOTAL, coordinate width (10), SYNC_POL default.
- One sub-module natural: pix_tick_gen (clk_25M register + rising-edge detect, async active-low reset).
- Remainder (counters + decode registers) in vga_sync_gen.

## Test plan
- Divider model drives clk_25M (2 high/2 low) after reset release → pix_tick exactly every 4 clk, single-cycle wide, first one in the cycle clk_25M first sampled high.
- Count ticks over one line → hsync period 800 ticks, asserted 96 ticks, asserts 656 ticks after video_on rises at x=0.
- Count over two frames → vsync period 420000 ticks, asserted 1600 ticks, frame_start once per frame coincident with x=0,y=0,video_on=1.
- Scoreboard a full frame → video_on high 640×480 = 307200 ticks; x sweeps 0..639, y 0..479; x=y=0 whenever video_on=0.
- Assert rst at h_cnt=300, v_cnt=200 → same cycle hsync=vsync=1, video_on=0, x=y=0; after release the sequence restarts at (0,0).
- Hold clk_25M low 100 clk mid-line → no pix_tick, all outputs constant; resume → counting continues from the held position.
